xfer_cu: RTL and testbench
==========================

# xfer_cu

Parametrised control unit that sequences two-memory datapaths: an optional fill phase writing memory A, then a copy phase streaming A into B, with an optional per-word filter. It drives the write-enable, address-increment and address-clear strobes of the A/B address counters and exposes a start/busy/done handshake to the surrounding controller. It supersedes the fixed-length, free-running control unit by adding programmable length, three modes, filtering and a write count.

## Interface
Parameters:
- ADDR_W, 3, width of the A/B address counters; maximum transfer length is 2^ADDR_W words.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-low reset; sampled on clk rising edge; overrides all other inputs.
- start  in  1  begin a transfer; sampled only in IDLE.
- mode  in  2  0 = fill then copy, 1 = copy only, 2 = filtered copy, 3 = reserved; captured on start.
- len  in  ADDR_W+1  word count, 0..2^ADDR_W; captured on start.
- keep  in  1  filter predicate from the datapath for the current A word; used only in COPY with mode 2.
- WEA  out  1  write enable, memory A.
- IncA  out  1  increment A address counter.
- WEB  out  1  write enable, memory B.
- IncB  out  1  increment B address counter.
- clrA  out  1  clear A address counter to 0.
- clrB  out  1  clear B address counter to 0.
- busy  out  1  high in CLR, FILL, REWIND and COPY.
- done  out  1  one-cycle completion pulse.
- count_b  out  ADDR_W+1  words written to B by the last or current transfer.

## Operation
- States: IDLE, CLR, FILL, REWIND, COPY, DONE. Internal word counter cnt is ADDR_W+1 bits wide, with captured mode_r and len_r.
- Strobe outputs are decoded combinationally from the state (plus keep in COPY). count_b is a register.
- IDLE: all strobes 0. If start=1 and mode≠3, capture mode and len, then go to CLR. start with mode=3 is ignored and the block stays in IDLE.
- CLR (1 cycle): clrA=1, clrB=1, cnt←0, count_b←0.
  - len_r=0 → DONE.
  - mode_r=0 → FILL.
  - Otherwise → COPY.
- FILL: WEA=1, IncA=1 every cycle, cnt+1 each cycle. When cnt=len_r−1 → REWIND. Exactly len_r writes occur.
- REWIND (1 cycle): clrA=1, cnt←0, then → COPY. This also provides the one-cycle read latency of memory A.
- COPY: IncA=1 every cycle, cnt+1 each cycle.
  - WEB=IncB=1 when mode_r≠2, or when mode_r=2 and keep=1.
  - count_b increments on each cycle with WEB=1.
  - When cnt=len_r−1 → DONE.
- DONE (1 cycle): done=1, busy=0, all strobes 0, then → IDLE. count_b holds until the next CLR.
- start while busy or in DONE is ignored and is not queued.
- len=2^ADDR_W is legal. The A/B address counters wrap to 0 after the last increment, and that wrap is harmless because the next transfer begins with clr.
- Reset (rst=0 at an edge): state←IDLE, cnt←0, count_b←0, mode_r/len_r←0. Reset mid-transfer aborts without a done pulse.

## Timing
- Reset values: WEA=IncA=WEB=IncB=clrA=clrB=busy=done=0, count_b=0.
- Cycle numbering: start sampled high at edge k means CLR is the state in cycle k+1.
- Mode 0, len L≥1:
  - FILL cycles k+2..k+1+L.
  - REWIND k+2+L.
  - COPY k+3+L..k+2+2L.
  - done high in cycle k+3+2L.
  - Latency from start to done is 2L+3.
- Modes 1/2, len L≥1: COPY k+2..k+1+L, done in cycle k+2+L (latency L+2).
- len=0 (any valid mode): done in cycle k+2.
- Earliest restart: start sampled in the IDLE cycle after DONE.
- keep is sampled combinationally in the same cycle as the WEB/IncB it gates.
- Outputs respond to state changes in the cycle after the edge, including reset.

## Test plan
- Reset: hold rst=0 for 2 edges during an active transfer → all outputs 0, count_b=0, state IDLE; no done pulse follows.
- Mode 0, len=8, ADDR_W=3:
  - WEA=IncA=1 for exactly 8 cycles, then clrA for 1 cycle.
  - IncA=IncB=WEB=1 for 8 cycles.
  - done exactly 19 cycles after start; count_b=8.
- Mode 2, len=8, keep sequence 1,0,1,1,0,0,1,0 → IncA high for 8 cycles, WEB/IncB high only in COPY cycles 1,3,4,7, count_b=4, done at start+10.
- len=0 in mode 1 → clrA=clrB pulse, done at start+2, WEA/WEB never asserted, count_b=0.
- Mode 1, len=3: assert start during COPY and with mode=3 from IDLE → first start is ignored, done at start+5 for the original transfer only; mode=3 start leaves busy=0.
- Back-to-back: mode 1 len=4 followed by start in the IDLE cycle after done → second done 6 cycles later; count_b reads 4 after each transfer.

Source files
------------

// File: rtl/xfer_cu.sv
// Two-memory transfer sequencer: optional fill of A, then copy A->B with optional
// per-word filter; drives address-counter strobes and a start/busy/done handshake.
module xfer_cu #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W:0]   len,
  input  logic              keep,
  output logic              WEA,
  output logic              IncA,
  output logic              WEB,
  output logic              IncB,
  output logic              clrA,
  output logic              clrB,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count_b
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FILL, S_REWIND, S_COPY, S_DONE
  } state_t;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t          r_state;
  logic [ADDR_W:0] r_cnt;
  logic [ADDR_W:0] r_len;
  logic [1:0]      r_mode;
  logic [ADDR_W:0] r_count_b;
  logic            w_last;
  logic            w_wr_b;

  // len_r is nonzero whenever FILL/COPY is reached, so len_r-1 never underflows there
  assign w_last  = (r_cnt == r_len - ONE);
  assign w_wr_b  = (r_state == S_COPY) && ((r_mode != 2'd2) || keep);
  assign count_b = r_count_b;

  always_comb begin
    WEA  = 1'b0;
    IncA = 1'b0;
    WEB  = 1'b0;
    IncB = 1'b0;
    clrA = 1'b0;
    clrB = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_CLR:    begin clrA = 1'b1; clrB = 1'b1; busy = 1'b1; end
      S_FILL:   begin WEA = 1'b1; IncA = 1'b1; busy = 1'b1; end
      S_REWIND: begin clrA = 1'b1; busy = 1'b1; end
      S_COPY:   begin IncA = 1'b1; WEB = w_wr_b; IncB = w_wr_b; busy = 1'b1; end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_len     <= '0;
      r_mode    <= '0;
      r_count_b <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (mode != 2'd3)) begin
            r_mode  <= mode;
            r_len   <= len;
            r_state <= S_CLR;
          end
        end
        S_CLR: begin
          r_cnt     <= '0;
          r_count_b <= '0;
          if (r_len == '0)        r_state <= S_DONE;
          else if (r_mode == 2'd0) r_state <= S_FILL;
          else                    r_state <= S_COPY;
        end
        S_FILL: begin
          r_cnt <= r_cnt + ONE;
          if (w_last) r_state <= S_REWIND;
        end
        S_REWIND: begin
          // A counter is cleared here; this cycle also covers A's read latency
          r_cnt   <= '0;
          r_state <= S_COPY;
        end
        S_COPY: begin
          r_cnt <= r_cnt + ONE;
          if (w_wr_b) r_count_b <= r_count_b + ONE;
          if (w_last) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xfer_cu.sv
// Randomized bench for xfer_cu: expected per-cycle strobes derived from phase
// arithmetic (fill/rewind/copy cycle ranges) and a running write count.
module tb_xfer_cu;
  localparam int ADDR_W = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      mode;
  logic [ADDR_W:0] len;
  logic            keep;
  logic            WEA, IncA, WEB, IncB, clrA, clrB, busy, done;
  logic [ADDR_W:0] count_b;

  int n_cmp = 0;
  int n_err = 0;
  int prev_cnt = 0;

  localparam logic [7:0] E_CLR  = 8'b0000_1110;
  localparam logic [7:0] E_FILL = 8'b1100_0010;
  localparam logic [7:0] E_REW  = 8'b0000_1010;
  localparam logic [7:0] E_COPY = 8'b0100_0010;
  localparam logic [7:0] E_WRB  = 8'b0011_0000;
  localparam logic [7:0] E_DONE = 8'b0000_0001;

  wire [7:0] outs = {WEA, IncA, WEB, IncB, clrA, clrB, busy, done};

  xfer_cu #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len), .keep(keep),
    .WEA(WEA), .IncA(IncA), .WEB(WEB), .IncB(IncB), .clrA(clrA), .clrB(clrB),
    .busy(busy), .done(done), .count_b(count_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One full transfer; the start cycle doubles as an IDLE check.
  task automatic run_xfer(input int md, input int L, input bit use_pat,
                          input logic [7:0] pat, input bit spur);
    logic [7:0] kp;
    logic [7:0] e;
    logic       kv;
    int total, cs, wr, idx;
    bit incopy;
    kp    = use_pat ? pat : 8'($urandom);
    total = (L == 0) ? 2 : ((md == 0) ? 2*L + 3 : L + 2);
    cs    = (md == 0) ? L + 3 : 2;
    @(negedge clk);
    start = 1'b1; mode = 2'(md); len = (ADDR_W+1)'(L); keep = 1'($urandom); #1;
    chk("idle_out", outs, 8'h00);
    chk("idle_cnt", count_b, prev_cnt);
    wr = 0;
    for (int j = 1; j <= total; j++) begin
      @(negedge clk);
      start = spur && (j == 2) && (j < total);
      if (start) mode = 2'($urandom_range(0, 3));
      incopy = (L > 0) && (j >= cs) && (j < cs + L);
      idx = j - cs;
      kv = incopy ? kp[idx[2:0]] : 1'($urandom);
      keep = kv; #1;
      if (j == 1)          e = E_CLR;
      else if (j == total) e = E_DONE;
      else if (incopy)     e = E_COPY | (((md != 2) || kv) ? E_WRB : 8'h00);
      else if (j == L + 2) e = E_REW;
      else                 e = E_FILL;
      chk($sformatf("out m%0d L%0d c%0d", md, L, j), outs, e);
      chk($sformatf("cnt m%0d L%0d c%0d", md, L, j), count_b, (j == 1) ? prev_cnt : wr);
      if (incopy && ((md != 2) || kv)) wr++;
    end
    start = 1'b0;
    prev_cnt = wr;
  endtask

  task automatic run_mode3();
    @(negedge clk);
    start = 1'b1; mode = 2'd3; len = (ADDR_W+1)'($urandom_range(0, 8)); #1;
    chk("m3_idle", outs, 8'h00);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      start = 1'b0; #1;
      chk("m3_out", outs, 8'h00);
      chk("m3_cnt", count_b, prev_cnt);
    end
  endtask

  task automatic run_abort();
    @(negedge clk);
    start = 1'b1; mode = 2'd0; len = 4'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk); #1;
      chk("rst_out", outs, 8'h00);
      chk("rst_cnt", count_b, 0);
    end
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); #1;
      chk("post_rst_out", outs, 8'h00);
    end
    prev_cnt = 0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = 2'd0; len = '0; keep = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_out", outs, 8'h00);
    chk("reset_cnt", count_b, 0);
    rst = 1'b1;

    run_xfer(0, 8, 1'b0, 8'h00, 1'b0);
    run_xfer(2, 8, 1'b1, 8'b0100_1101, 1'b0);
    run_xfer(1, 0, 1'b0, 8'h00, 1'b0);
    run_xfer(1, 3, 1'b0, 8'h00, 1'b1);
    run_mode3();
    run_xfer(1, 4, 1'b0, 8'h00, 1'b0);
    run_xfer(1, 4, 1'b0, 8'h00, 1'b0);
    run_abort();
    run_xfer(1, 3, 1'b0, 8'h00, 1'b0);
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 7) == 0) run_mode3();
      run_xfer($urandom_range(0, 2), $urandom_range(0, 8), 1'b0, 8'h00,
               1'($urandom_range(0, 1)));
    end
    run_xfer(0, 0, 1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
